// File: rtl/eq_coeff_pkg.sv
// Shared constants, types and address helper for the equalizer coefficient store.
// Entries are laid out band-major: address = band*COEFFS_PER_BAND + index.
package eq_coeff_pkg;

  localparam int NUM_BANDS       = 8;
  localparam int COEFFS_PER_BAND = 5;
  localparam int COEFF_W         = 16;
  localparam int ADDR_W          = 6;
  localparam int DEPTH           = NUM_BANDS * COEFFS_PER_BAND;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  // Q2.14 value of +1.0; a biquad with b0 = UNITY and all else 0 is a wire.
  localparam coeff_t UNITY = 16'h4000;

  typedef enum logic [2:0] {
    IDX_B0 = 3'd0,
    IDX_B1 = 3'd1,
    IDX_B2 = 3'd2,
    IDX_A1 = 3'd3,
    IDX_A2 = 3'd4
  } coeff_idx_e;

  function automatic addr_t coeff_addr(input int unsigned band, input coeff_idx_e idx);
    return addr_t'(band * COEFFS_PER_BAND + int'(idx));
  endfunction

endpackage

// File: rtl/coeff_bank_if.sv
// Write/swap/read bus between the input register, the swap controller,
// the filter datapath and the coefficient bank.
interface coeff_bank_if;
  import eq_coeff_pkg::*;

  logic   i_wr_en;
  addr_t  i_wr_addr;
  coeff_t i_wr_data;
  logic   i_coeffs_en;
  addr_t  i_rd_addr;
  coeff_t o_rd_data;
  logic   o_swap_done;
  logic   o_dirty;
  addr_t  o_wr_count;
  logic   o_addr_err;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_coeffs_en, i_rd_addr,
    input  o_rd_data, o_swap_done, o_dirty, o_wr_count, o_addr_err
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_coeffs_en, i_rd_addr,
    output o_rd_data, o_swap_done, o_dirty, o_wr_count, o_addr_err
  );

endinterface

// File: rtl/coeff_slot.sv
// One coefficient entry: a shadow register written serially and an active
// register that takes the shadow value on swap.
module coeff_slot
  import eq_coeff_pkg::*;
#(
  parameter coeff_t INIT = '0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clk_enable,
  input  logic   wr_en,
  input  coeff_t wr_data,
  input  logic   swap,
  output coeff_t active
);

  coeff_t shadow;

  // NOTE: both banks are real registers with a defined reset value, not RAM;
  // the filter must see a passthrough response straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= INIT;
      active <= INIT;
    end else if (clk_enable) begin
      // NOTE: non-blocking assignment makes the swap copy the pre-edge shadow,
      // so a write on the same edge lands only in the shadow.
      if (wr_en) shadow <= wr_data;
      if (swap)  active <= shadow;
    end
  end

endmodule

// File: rtl/coeff_bank.sv
// Double-buffered coefficient store: serial writes fill the shadow bank, a swap
// request copies it atomically to the active bank read by the filter datapath.
module coeff_bank
  import eq_coeff_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_enable,
  coeff_bank_if.slave  bus
);

  localparam addr_t DEPTH_A   = addr_t'(DEPTH);
  localparam addr_t COUNT_MAX = '1;

  coeff_t active [DEPTH];
  coeff_t rd_mux;
  logic   wr_valid;
  logic   rd_valid;
  logic   wr_ok;

  assign wr_valid = bus.i_wr_addr < DEPTH_A;
  assign rd_valid = bus.i_rd_addr < DEPTH_A;
  assign wr_ok    = bus.i_wr_en && wr_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    localparam coeff_t INIT = ((k % COEFFS_PER_BAND) == int'(IDX_B0)) ? UNITY : '0;

    coeff_slot #(.INIT(INIT)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .clk_enable (clk_enable),
      .wr_en      (wr_ok && (bus.i_wr_addr == addr_t'(k))),
      .wr_data    (bus.i_wr_data),
      .swap       (bus.i_coeffs_en),
      .active     (active[k])
    );
  end

  // NOTE: default first so every path assigns rd_mux and no latch is inferred.
  always_comb begin
    rd_mux = '0;
    if (rd_valid) rd_mux = active[bus.i_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.o_rd_data   <= '0;
      bus.o_swap_done <= 1'b0;
      bus.o_dirty     <= 1'b0;
      bus.o_wr_count  <= '0;
      bus.o_addr_err  <= 1'b0;
    end else if (clk_enable) begin
      bus.o_rd_data   <= rd_mux;
      bus.o_swap_done <= bus.i_coeffs_en;

      if ((bus.i_wr_en && !wr_valid) || !rd_valid) bus.o_addr_err <= 1'b1;

      // A write on the swap edge stays pending in the shadow, so it counts as
      // the first write of the next batch.
      if (bus.i_coeffs_en) begin
        bus.o_dirty    <= wr_ok;
        bus.o_wr_count <= wr_ok ? addr_t'(1) : '0;
      end else if (wr_ok) begin
        bus.o_dirty <= 1'b1;
        if (bus.o_wr_count != COUNT_MAX) bus.o_wr_count <= bus.o_wr_count + addr_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_coeff_bank.sv
// Self-checking bench for coeff_bank: directed scenarios plus a randomized phase,
// all compared against an array-level model of the two banks and status outputs.
module tb_coeff_bank;
  import eq_coeff_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_enable = 1'b0;

  coeff_bank_if bus ();

  coeff_bank dut (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: whole banks as arrays, status as plain integers.
  logic [15:0] sh_m [DEPTH];
  logic [15:0] ac_m [DEPTH];
  logic [15:0] rd_m;
  logic        sd_m, dirty_m, err_m;
  int          cnt_m;

  function automatic logic [15:0] init_val(input int a);
    return ((a % COEFFS_PER_BAND) == 0) ? 16'h4000 : 16'h0000;
  endfunction

  task automatic model_edge();
    logic [15:0] rd_next;
    int ra, wa;
    ra = int'(bus.i_rd_addr);
    wa = int'(bus.i_wr_addr);
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sh_m[k] = init_val(k);
        ac_m[k] = init_val(k);
      end
      rd_m = 16'h0; sd_m = 1'b0; dirty_m = 1'b0; cnt_m = 0; err_m = 1'b0;
    end else if (clk_enable) begin
      if (ra < DEPTH) rd_next = ac_m[ra];
      else begin
        rd_next = 16'h0;
        err_m   = 1'b1;
      end
      if (bus.i_wr_en && wa >= DEPTH) err_m = 1'b1;
      if (bus.i_coeffs_en) begin
        for (int k = 0; k < DEPTH; k++) ac_m[k] = sh_m[k];
        dirty_m = 1'b0;
        cnt_m   = 0;
      end
      if (bus.i_wr_en && wa < DEPTH) begin
        sh_m[wa] = bus.i_wr_data;
        dirty_m  = 1'b1;
        cnt_m    = (cnt_m < 63) ? cnt_m + 1 : 63;
      end
      sd_m = bus.i_coeffs_en;
      rd_m = rd_next;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, "_rd"},    32'(bus.o_rd_data),   32'(rd_m));
    cmp({tag, "_swap"},  32'(bus.o_swap_done), 32'(sd_m));
    cmp({tag, "_dirty"}, 32'(bus.o_dirty),     32'(dirty_m));
    cmp({tag, "_count"}, 32'(bus.o_wr_count),  32'(cnt_m));
    cmp({tag, "_err"},   32'(bus.o_addr_err),  32'(err_m));
  endtask

  task automatic idle();
    bus.i_wr_en     = 1'b0;
    bus.i_wr_addr   = '0;
    bus.i_wr_data   = '0;
    bus.i_coeffs_en = 1'b0;
    bus.i_rd_addr   = '0;
  endtask

  // Reads every address with explicit passthrough expectations.
  task automatic read_passthrough(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      bus.i_rd_addr = addr_t'(a);
      step();
      cmp(tag, 32'(bus.o_rd_data), 32'(init_val(a)));
    end
    check_model(tag);
  endtask

  initial begin
    addr_t a7, a3;
    a7 = coeff_addr(1, IDX_B2);
    a3 = coeff_addr(0, IDX_A1);

    // 1: reset and passthrough contents
    idle();
    rst = 1'b0;
    clk_enable = 1'b1;
    step();
    step();
    cmp("rst_rd",    32'(bus.o_rd_data),   32'h0);
    cmp("rst_swap",  32'(bus.o_swap_done), 32'h0);
    cmp("rst_dirty", 32'(bus.o_dirty),     32'h0);
    cmp("rst_count", 32'(bus.o_wr_count),  32'h0);
    cmp("rst_err",   32'(bus.o_addr_err),  32'h0);
    rst = 1'b1;
    read_passthrough("t1_read");

    // 2: shadow write invisible until swap
    bus.i_wr_en = 1'b1; bus.i_wr_addr = a7; bus.i_wr_data = 16'h1234;
    bus.i_rd_addr = a7;
    step();
    bus.i_wr_en = 1'b0;
    step();
    cmp("t2_rd_pre",  32'(bus.o_rd_data),  32'h0);
    cmp("t2_dirty",   32'(bus.o_dirty),    32'h1);
    cmp("t2_count",   32'(bus.o_wr_count), 32'h1);
    bus.i_coeffs_en = 1'b1;
    step();
    bus.i_coeffs_en = 1'b0;
    cmp("t2_swap_hi", 32'(bus.o_swap_done), 32'h1);
    cmp("t2_rd_swap", 32'(bus.o_rd_data),   32'h0);
    step();
    cmp("t2_swap_lo", 32'(bus.o_swap_done), 32'h0);
    cmp("t2_rd_post", 32'(bus.o_rd_data),   32'h1234);
    cmp("t2_clean",   32'(bus.o_dirty),     32'h0);
    cmp("t2_zero",    32'(bus.o_wr_count),  32'h0);
    check_model("t2");

    // 3: write and swap on the same edge
    bus.i_wr_en = 1'b1; bus.i_wr_addr = a3; bus.i_wr_data = 16'hBEEF;
    bus.i_coeffs_en = 1'b1; bus.i_rd_addr = a3;
    step();
    idle();
    bus.i_rd_addr = a3;
    step();
    cmp("t3_rd_old", 32'(bus.o_rd_data),  32'h0);
    cmp("t3_dirty",  32'(bus.o_dirty),    32'h1);
    cmp("t3_count",  32'(bus.o_wr_count), 32'h1);
    bus.i_coeffs_en = 1'b1;
    step();
    bus.i_coeffs_en = 1'b0;
    step();
    cmp("t3_rd_new", 32'(bus.o_rd_data), 32'hBEEF);
    check_model("t3");

    // Randomized traffic on valid addresses with a gappy clock enable
    for (int i = 0; i < 400; i++) begin
      clk_enable      = ($urandom_range(4) != 0);
      bus.i_wr_en     = $urandom_range(1);
      bus.i_wr_addr   = addr_t'($urandom_range(DEPTH - 1));
      bus.i_wr_data   = coeff_t'($urandom);
      bus.i_coeffs_en = ($urandom_range(7) == 0);
      bus.i_rd_addr   = addr_t'($urandom_range(DEPTH - 1));
      step();
      check_model("rand");
    end
    clk_enable = 1'b1;
    idle();
    step();

    // 4: out-of-range write and read
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 6'd45; bus.i_wr_data = 16'hFFFF;
    step();
    bus.i_wr_en = 1'b0;
    cmp("t4_err_wr", 32'(bus.o_addr_err), 32'h1);
    bus.i_coeffs_en = 1'b1;
    step();
    bus.i_coeffs_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.i_rd_addr = addr_t'(a);
      step();
      check_model("t4_scan");
    end
    bus.i_rd_addr = 6'd50;
    step();
    cmp("t4_rd_oob", 32'(bus.o_rd_data), 32'h0);
    bus.i_rd_addr = '0;
    step();
    cmp("t4_sticky", 32'(bus.o_addr_err), 32'h1);
    check_model("t4");

    // 5: clock enable low freezes everything, then saturation
    bus.i_coeffs_en = 1'b1;
    step();
    clk_enable = 1'b0;
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 6'd2; bus.i_wr_data = 16'h5555;
    bus.i_rd_addr = 6'd10;
    for (int i = 0; i < 3; i++) begin
      step();
      check_model("t5_hold");
    end
    cmp("t5_swap_held", 32'(bus.o_swap_done), 32'h1);
    clk_enable = 1'b1;
    bus.i_coeffs_en = 1'b0;
    for (int i = 0; i < 70; i++) begin
      bus.i_wr_addr = addr_t'(i % DEPTH);
      bus.i_wr_data = coeff_t'($urandom);
      step();
    end
    bus.i_wr_en = 1'b0;
    cmp("t5_sat", 32'(bus.o_wr_count), 32'd63);
    check_model("t5");

    // 6: reset on a swap edge
    bus.i_coeffs_en = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 6'd1; bus.i_wr_data = 16'h7777;
    rst = 1'b0;
    step();
    cmp("t6_swap", 32'(bus.o_swap_done), 32'h0);
    cmp("t6_err",  32'(bus.o_addr_err),  32'h0);
    check_model("t6");
    rst = 1'b1;
    idle();
    read_passthrough("t6_active");
    bus.i_coeffs_en = 1'b1;
    step();
    bus.i_coeffs_en = 1'b0;
    read_passthrough("t6_shadow");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
